// File: rtl/adc_test_source.sv
// Multi-channel ADC stimulus generator: DDS tone, ramp, PRBS15 or zero with per-channel phase offset,
// optional finite burst length and valid/ready backpressure on a 3-stage pipeline.
module adc_test_source #(
  parameter int NCH    = 2,
  parameter int DW     = 12,
  parameter int PW     = 32,
  parameter int LUT_AW = 10,
  parameter int CNTW   = 16
) (
  input  logic                sysclk,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [1:0]          cfg_mode_i,
  input  logic [PW-1:0]       cfg_ftw_i,
  input  logic [NCH*16-1:0]   cfg_poff_i,
  input  logic [CNTW-1:0]     cfg_count_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [NCH*DW-1:0]   out_data_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int N     = 1 << LUT_AW;
  localparam int AMP_I = (1 << (DW - 1)) - 1;
  localparam logic [DW-1:0] AMP = DW'(AMP_I);

  typedef enum logic [1:0] {
    MODE_ZERO = 2'd0,
    MODE_TONE = 2'd1,
    MODE_RAMP = 2'd2,
    MODE_PRBS = 2'd3
  } mode_t;

  // Elaboration-time round(AMP*sin(pi/2*k/N)) using a Q48 fixed-point Taylor series.
  function automatic logic [DW-1:0] sine_q(input int k);
    logic signed [127:0] x, x2, term, sum, den;
    x    = (128'sh3243F6A8885A3 * 128'(k)) >>> (LUT_AW + 1);
    x2   = (x * x) >>> 48;
    term = x;
    sum  = x;
    for (int i = 1; i <= 12; i++) begin
      den  = 128'((2 * i) * (2 * i + 1));
      term = -(((term * x2) >>> 48) / den);
      sum  = sum + term;
    end
    return DW'((sum * 128'(AMP_I) + (128'sd1 <<< 47)) >>> 48);
  endfunction

  function automatic logic [14:0] prbs_step(input logic [14:0] s);
    return {s[13:0], s[14] ^ s[13]};
  endfunction

  logic [DW-1:0] lut_s [N];
  for (genvar gi = 0; gi < N; gi++) begin : g_lut
    localparam logic [DW-1:0] LV = sine_q(gi);
    assign lut_s[gi] = LV;
  end

  logic                cfg_ready_r, busy_r, cont_r;
  mode_t               sh_mode_r, mode_r;
  logic [PW-1:0]       sh_ftw_r, ftw_r, acc_r;
  logic [NCH*16-1:0]   sh_poff_r, poff_r;
  logic [CNTW-1:0]     sh_count_r, iss_rem_r;
  logic [14:0]         lfsr_r [NCH];
  logic                p0_valid_r, p0_last_r, p1_valid_r, p1_last_r, out_valid_r, out_last_r;
  logic [PW-1:0]       p0_phase_r;
  logic [DW-1:0]       p0_prbs_r [NCH];
  logic [DW-1:0]       p1_raw_r [NCH];
  logic [NCH-1:0]      p1_neg_r;
  logic [NCH*DW-1:0]   out_data_r;

  logic                adv_s, accept_s, cfg_acc_s, apply_s, issue_s;
  logic [PW-1:0]       ph_s [NCH];
  logic [1:0]          q_s [NCH];
  logic [LUT_AW-1:0]   a_s [NCH];
  logic [LUT_AW-1:0]   idx_s [NCH];
  logic [DW-1:0]       mag_s [NCH];
  logic [DW-1:0]       raw_s [NCH];
  logic [NCH-1:0]      neg_s;
  logic [NCH-1:0]      ph_unused_s;

  // Handshake and pipeline control; a pending shadow config blocks issue so the pipe can drain.
  always_comb begin
    adv_s     = !(out_valid_r && !out_ready_i);
    accept_s  = out_valid_r && out_ready_i;
    cfg_acc_s = cfg_valid_i && cfg_ready_r;
    apply_s   = !cfg_ready_r && !p0_valid_r && !p1_valid_r && !out_valid_r;
    issue_s   = adv_s && enable_i && busy_r && cfg_ready_r &&
                (cont_r || (iss_rem_r != {CNTW{1'b0}}));
  end

  // S1 datapath: per-channel phase, quadrant fold into the quarter-wave table, mode select.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      ph_s[k] = p0_phase_r + {poff_r[16*k +: 16], {(PW-16){1'b0}}};
      q_s[k]  = ph_s[k][PW-1 -: 2];
      a_s[k]  = ph_s[k][PW-3 -: LUT_AW];
      if (q_s[k][0]) begin
        idx_s[k] = ~a_s[k] + {{(LUT_AW-1){1'b0}}, 1'b1};
      end else begin
        idx_s[k] = a_s[k];
      end
      // Odd quadrant at a==0 is the peak, which lies one entry beyond the table.
      if (q_s[k][0] && (a_s[k] == {LUT_AW{1'b0}})) begin
        mag_s[k] = AMP;
      end else begin
        mag_s[k] = lut_s[idx_s[k]];
      end
      case (mode_r)
        MODE_TONE: raw_s[k] = mag_s[k];
        MODE_RAMP: raw_s[k] = ph_s[k][PW-1 -: DW];
        MODE_PRBS: raw_s[k] = p0_prbs_r[k];
        default:   raw_s[k] = {DW{1'b0}};
      endcase
      neg_s[k] = (mode_r == MODE_TONE) && q_s[k][1];
    end
  end

  for (genvar gk = 0; gk < NCH; gk++) begin : g_unused
    assign ph_unused_s[gk] = ^ph_s[gk];
  end

  // Config shadow/apply, accumulator, LFSRs, burst counting and the three pipeline stages.
  always_ff @(posedge sysclk) begin
    if (rst_i) begin
      cfg_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      cont_r      <= 1'b0;
      sh_mode_r   <= MODE_ZERO;
      mode_r      <= MODE_ZERO;
      sh_ftw_r    <= {PW{1'b0}};
      ftw_r       <= {PW{1'b0}};
      acc_r       <= {PW{1'b0}};
      sh_poff_r   <= {(NCH*16){1'b0}};
      poff_r      <= {(NCH*16){1'b0}};
      sh_count_r  <= {CNTW{1'b0}};
      iss_rem_r   <= {CNTW{1'b0}};
      p0_valid_r  <= 1'b0;
      p0_last_r   <= 1'b0;
      p0_phase_r  <= {PW{1'b0}};
      p1_valid_r  <= 1'b0;
      p1_last_r   <= 1'b0;
      p1_neg_r    <= {NCH{1'b0}};
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= {(NCH*DW){1'b0}};
      for (int k = 0; k < NCH; k++) begin
        lfsr_r[k]    <= 15'h7FFF ^ 15'(k);
        p0_prbs_r[k] <= {DW{1'b0}};
        p1_raw_r[k]  <= {DW{1'b0}};
      end
    end else begin
      if (cfg_acc_s) begin
        cfg_ready_r <= 1'b0;
        sh_mode_r   <= mode_t'(cfg_mode_i);
        sh_ftw_r    <= cfg_ftw_i;
        sh_poff_r   <= cfg_poff_i;
        sh_count_r  <= cfg_count_i;
      end
      if (apply_s) begin
        cfg_ready_r <= 1'b1;
        mode_r      <= sh_mode_r;
        ftw_r       <= sh_ftw_r;
        poff_r      <= sh_poff_r;
        acc_r       <= {PW{1'b0}};
        iss_rem_r   <= sh_count_r;
        cont_r      <= (sh_count_r == {CNTW{1'b0}});
        busy_r      <= 1'b1;
        for (int k = 0; k < NCH; k++) begin
          lfsr_r[k] <= 15'h7FFF ^ 15'(k);
        end
      end else begin
        if (issue_s) begin
          acc_r <= acc_r + ftw_r;
          if (!cont_r) begin
            iss_rem_r <= iss_rem_r - {{(CNTW-1){1'b0}}, 1'b1};
          end
          for (int k = 0; k < NCH; k++) begin
            lfsr_r[k] <= prbs_step(lfsr_r[k]);
          end
        end
        if (accept_s && out_last_r) begin
          busy_r <= 1'b0;
        end
      end
      if (adv_s) begin
        p0_valid_r <= issue_s;
        if (issue_s) begin
          p0_phase_r <= acc_r;
          p0_last_r  <= !cont_r && (iss_rem_r == {{(CNTW-1){1'b0}}, 1'b1});
          for (int k = 0; k < NCH; k++) begin
            p0_prbs_r[k] <= lfsr_r[k][DW-1:0];
          end
        end
        p1_valid_r <= p0_valid_r;
        if (p0_valid_r) begin
          p1_last_r <= p0_last_r;
          p1_neg_r  <= neg_s;
          for (int k = 0; k < NCH; k++) begin
            p1_raw_r[k] <= raw_s[k];
          end
        end
        out_valid_r <= p1_valid_r;
        if (p1_valid_r) begin
          out_last_r <= p1_last_r;
          for (int k = 0; k < NCH; k++) begin
            out_data_r[DW*k +: DW] <= p1_neg_r[k] ? (~p1_raw_r[k] + {{(DW-1){1'b0}}, 1'b1})
                                                  : p1_raw_r[k];
          end
        end
      end
    end
  end

  assign cfg_ready_o = cfg_ready_r;
  assign out_valid_o = out_valid_r;
  assign out_data_o  = out_data_r;
  assign busy_o      = busy_r;
  assign done_o      = accept_s && out_last_r;

endmodule
